// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, divider width and data-width helpers.
package uart_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY,
    STOP_BIT
  } rx_state_e;

  // cfg_bits encoding 00..11 selects 5..8 data bits
  function automatic logic [3:0] bits_count(input logic [1:0] bits);
    return 4'd5 + {2'b00, bits};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    logic [7:0] m;
    m = 8'hFF;
    return m >> (2'd3 - bits);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx line synchroniser: SYNC_STAGES flops (reset high) plus a falling-edge strobe on the synced line.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], rx_i};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign rx_s = chain[SYNC_STAGES-1];
  assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 5-8 data bits, optional even parity, valid/ready character output.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 mid-bit voting on every bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  output logic             busy_o,
  input  logic             cfg_en_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_parity_en_i,
  input  logic [1:0]       cfg_bits_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_parity_err_o,
  output logic             rx_frame_err_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             rx_overrun_o
);

  logic             rx_s, fall;
  rx_state_e        state;
  logic [DIV_W-1:0] cnt, mid;
  logic [2:0]       idx, last_idx;
  logic [7:0]       shift;
  logic             par, par_err;
  logic             tick_start, tick_bit, bit_val, realign;
  logic             accept;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx_i  (rx_i),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign mid      = cfg_div_i >> 1;
  assign last_idx = 3'(bits_count(cfg_bits_i) - 4'd1);
  assign accept   = ~rx_valid_o | rx_ready_i;
  assign busy_o   = (state != IDLE);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic v0, v1, vote_on, maj;

  assign vote_on = (cfg_div_i >= DIV_W'(2));
  assign maj     = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if (cnt == mid - DIV_W'(1)) v0 <= rx_s;
      if (cnt == mid)             v1 <= rx_s;
    end
  end

  // Voting keeps the counter phase from the start edge, so every bit decides at mid+1.
  always_comb begin
    tick_start = (cnt == mid);
    tick_bit   = (cnt == cfg_div_i);
    bit_val    = rx_s;
    realign    = 1'b1;
    if (vote_on) begin
      tick_start = (cnt == mid + DIV_W'(1));
      tick_bit   = (cnt == mid + DIV_W'(1));
      bit_val    = maj;
      realign    = 1'b0;
    end
  end
`else
  // Clearing at mid-start puts every later wrap at the middle of a bit.
  assign tick_start = (cnt == mid);
  assign tick_bit   = (cnt == cfg_div_i);
  assign bit_val    = rx_s;
  assign realign    = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      shift           <= '0;
      par             <= 1'b0;
      par_err         <= 1'b0;
      rx_data_o       <= '0;
      rx_valid_o      <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_overrun_o    <= 1'b0;
    end else begin
      rx_overrun_o <= 1'b0;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;

      if (!cfg_en_i) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        // >= keeps a mid-frame divider shrink from running the counter out to 0xFFFF
        if (state == IDLE || cnt >= cfg_div_i) cnt <= '0;
        else                                   cnt <= cnt + DIV_W'(1);

        case (state)
          IDLE: begin
            if (fall) begin
              state   <= START_BIT;
              idx     <= '0;
              shift   <= '0;
              par     <= 1'b0;
              par_err <= 1'b0;
            end
          end
          START_BIT: begin
            if (tick_start) begin
              if (!bit_val) begin
                state <= DATA;
                if (realign) cnt <= '0;
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end
          end
          DATA: begin
            if (tick_bit) begin
              shift[idx] <= bit_val;
              par        <= par ^ bit_val;
              if (idx >= last_idx) state <= cfg_parity_en_i ? PARITY : STOP_BIT;
              else                 idx   <= idx + 3'd1;
            end
          end
          PARITY: begin
            if (tick_bit) begin
              par_err <= bit_val ^ par;
              state   <= STOP_BIT;
            end
          end
          STOP_BIT: begin
            if (tick_bit) begin
              state <= IDLE;
              cnt   <= '0;
              if (accept) begin
                rx_data_o       <= shift & data_mask(cfg_bits_i);
                rx_parity_err_o <= par_err;
                rx_frame_err_o  <= ~bit_val;
                rx_valid_o      <= 1'b1;
              end else begin
                rx_overrun_o <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected characters, a monitor pops on handshake.
module tb_uart_rx;

  localparam int DIV = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_i;
  logic        busy_o;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic        cfg_parity_en_i;
  logic [1:0]  cfg_bits_i;
  logic [7:0]  rx_data_o;
  logic        rx_parity_err_o;
  logic        rx_frame_err_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        rx_overrun_o;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt = 0;
  int   pushed = 0;
  int   popped = 0;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rx_i            (rx_i),
    .busy_o          (busy_o),
    .cfg_en_i        (cfg_en_i),
    .cfg_div_i       (cfg_div_i),
    .cfg_parity_en_i (cfg_parity_en_i),
    .cfg_bits_i      (cfg_bits_i),
    .rx_data_o       (rx_data_o),
    .rx_parity_err_o (rx_parity_err_o),
    .rx_frame_err_o  (rx_frame_err_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .rx_overrun_o    (rx_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (DIV + 1) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stop);
    rx_i = 1'b1;
    repeat (2 * (DIV + 1)) @(negedge clk_i);
  endtask

  // Monitor: every accepted character must match the head of the scoreboard
  always @(negedge clk_i) begin
    if (rx_overrun_o) ovr_cnt++;
    if (!rst_i && rx_valid_o && rx_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_char actual %0h required none", rx_data_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        check("rx_data", {24'd0, rx_data_o}, {24'd0, e.d});
        check("rx_parity_err", {31'd0, rx_parity_err_o}, {31'd0, e.pe});
        check("rx_frame_err", {31'd0, rx_frame_err_o}, {31'd0, e.fe});
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk_i);
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; rx_i = 1'b1; cfg_en_i = 1'b1; cfg_div_i = 16'(DIV);
    cfg_parity_en_i = 1'b0; cfg_bits_i = 2'b11; rx_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_valid", {31'd0, rx_valid_o}, 32'd0);
    check("reset_data", {24'd0, rx_data_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_errs", {30'd0, rx_parity_err_o, rx_frame_err_o}, 32'd0);
    check("reset_overrun", {31'd0, rx_overrun_o}, 32'd0);

    // 8N1 0xA5
    push(8'hA5, 1'b0, 1'b0);
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      begin
        repeat (40) @(negedge clk_i);
        check("busy_mid_frame", {31'd0, busy_o}, 32'd1);
      end
    join
    check("busy_after_stop", {31'd0, busy_o}, 32'd0);

    // even parity: 0x03 has XOR 0, so parity bit 1 is an error
    cfg_parity_en_i = 1'b1;
    push(8'h03, 1'b1, 1'b0);
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1);
    push(8'h03, 1'b0, 1'b0);
    send_frame(8'h03, 8, 1'b1, 1'b0, 1'b1);
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 8, 1'b1, 1'b0, 1'b1);
    cfg_parity_en_i = 1'b0;

    // 5-bit framing error then a clean frame
    cfg_bits_i = 2'b00;
    push(8'h15, 1'b0, 1'b1);
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b0);
    push(8'h0A, 1'b0, 1'b0);
    send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b1);
    cfg_bits_i = 2'b01;
    push(8'h2B, 1'b0, 1'b0);
    send_frame(8'h2B, 6, 1'b0, 1'b0, 1'b1);
    cfg_bits_i = 2'b11;

    // glitch: 4 low cycles
    rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("glitch_busy_start", {31'd0, busy_o}, 32'd1);
    repeat (30) @(negedge clk_i);
    check("glitch_busy_drop", {31'd0, busy_o}, 32'd0);
    check("glitch_no_valid", {31'd0, rx_valid_o}, 32'd0);

    // overrun
    rx_ready_i = 1'b0;
    ovr_cnt = 0;
    push(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    check("overrun_pulses", ovr_cnt, 32'd1);
    check("overrun_held_valid", {31'd0, rx_valid_o}, 32'd1);
    check("overrun_held_data", {24'd0, rx_data_o}, 32'h11);
    rx_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("overrun_valid_drop", {31'd0, rx_valid_o}, 32'd0);

    // reset mid-DATA with a character pending
    rx_ready_i = 1'b0;
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
    check("pending_valid", {31'd0, rx_valid_o}, 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    rx_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check("busy_in_data", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, rx_valid_o}, 32'd0);
    check("rst_mid_data", {24'd0, rx_data_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    check("rst_mid_errs", {30'd0, rx_parity_err_o, rx_frame_err_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    rx_ready_i = 1'b1;
    repeat (2 * (DIV + 1)) @(negedge clk_i);
    push(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk_i);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("chars_delivered", popped, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
